// File: rtl/benes_route_pipe.sv
// Pipelined Benes permutation network (N_PORTS padded to a power of two) with per-beat switch config.
// Optional macro BENES_PIPE_HALF_EN: register only after odd stages and the last stage.

module benes_sw #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y_lo,
    output logic [W-1:0] y_hi
);
    assign y_lo = sel ? b : a;
    assign y_hi = sel ? a : b;
endmodule

module benes_route_pipe #(
    parameter int  DATA_W  = 512,
    parameter int  N_PORTS = 20,
    localparam int LOG2N   = $clog2(N_PORTS),
    localparam int SIZE    = 1 << LOG2N,
    localparam int STAGES  = 2 * LOG2N - 1,
    localparam int SW_NUM  = SIZE / 2,
    localparam int CFG_W   = STAGES * SW_NUM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_cfg_valid,
    output logic                      o_cfg_ready,
    input  logic [CFG_W-1:0]          i_cfg_sel,
    input  logic                      i_valid,
    input  logic [N_PORTS*DATA_W-1:0] i_data,
    output logic                      o_valid,
    output logic [N_PORTS*DATA_W-1:0] o_data,
    output logic                      o_busy
);
`ifdef BENES_PIPE_HALF_EN
    localparam bit HALF = 1'b1;
`else
    localparam bit HALF = 1'b0;
`endif
    localparam int LAT   = HALF ? STAGES / 2 + 3 : STAGES + 2;
    localparam int CNT_W = $clog2(LAT + 1);

    logic [CFG_W-1:0] cfg_act, cfg_pend, beat_cfg;
    logic             pend_full, cfg_acc;

    // A beat frees the pending slot, so a new config may land in the same cycle.
    assign o_cfg_ready = !pend_full || i_valid;
    assign cfg_acc     = i_cfg_valid && o_cfg_ready;
    assign beat_cfg    = pend_full ? cfg_pend : cfg_act;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_act   <= '0;
            cfg_pend  <= '0;
            pend_full <= 1'b0;
        end else begin
            if (i_valid) begin
                cfg_act   <= cfg_pend;
                pend_full <= 1'b0;
            end
            if (cfg_acc) begin
                cfg_pend  <= i_cfg_sel;
                pend_full <= 1'b1;
            end
        end
    end

    logic [SIZE-1:0][DATA_W-1:0] pad_in, in_d;
    logic [CFG_W-1:0]            in_c;
    logic                        in_v;

    always_comb begin
        pad_in = '0;
        for (int p = 0; p < N_PORTS; p++) pad_in[p] = i_data[p*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_d <= '0;
            in_c <= '0;
            in_v <= 1'b0;
        end else begin
            in_d <= pad_in;
            in_c <= beat_cfg;
            in_v <= i_valid;
        end
    end

    // Each stage consumes the low SW_NUM config bits and shifts the rest onward.
    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int B     = (s < LOG2N) ? LOG2N - 1 - s : s - LOG2N + 1;
        localparam bit REG_S = !HALF || (s % 2 == 1) || (s == STAGES - 1);
        logic [SIZE-1:0][DATA_W-1:0] d_in, d_sw, d_out;
        logic [CFG_W-1:0]            c_in, c_out;
        logic                        v_in, v_out;

        if (s == 0) begin : g_src
            assign d_in = in_d;
            assign c_in = in_c;
            assign v_in = in_v;
        end else begin : g_src
            assign d_in = g_stg[s-1].d_out;
            assign c_in = g_stg[s-1].c_out;
            assign v_in = g_stg[s-1].v_out;
        end

        for (genvar j = 0; j < SW_NUM; j++) begin : g_sw
            localparam int LO = ((j >> B) << (B + 1)) | (j & ((1 << B) - 1));
            localparam int HI = LO + (1 << B);
            benes_sw #(.W(DATA_W)) u_sw (
                .sel (c_in[j]),
                .a   (d_in[LO]),
                .b   (d_in[HI]),
                .y_lo(d_sw[LO]),
                .y_hi(d_sw[HI])
            );
        end

        if (REG_S) begin : g_reg
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    d_out <= '0;
                    c_out <= '0;
                    v_out <= 1'b0;
                end else begin
                    d_out <= d_sw;
                    c_out <= c_in >> SW_NUM;
                    v_out <= v_in;
                end
            end
        end else begin : g_cmb
            assign d_out = d_sw;
            assign c_out = c_in >> SW_NUM;
            assign v_out = v_in;
        end
    end

    logic unused_tail;
    assign unused_tail = ^{g_stg[STAGES-1].c_out, g_stg[STAGES-1].d_out};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= g_stg[STAGES-1].v_out;
            if (g_stg[STAGES-1].v_out)
                for (int p = 0; p < N_PORTS; p++) o_data[p*DATA_W +: DATA_W] <= g_stg[STAGES-1].d_out[p];
        end
    end

    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (i_valid && !o_valid)      cnt_nxt = cnt + CNT_W'(1);
        else if (!i_valid && o_valid) cnt_nxt = cnt - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            o_busy <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            o_busy <= (cnt_nxt != '0);
        end
    end
endmodule

// File: tb/tb_benes_route_pipe.sv
// Directed bench for benes_route_pipe (N_PORTS=20, DATA_W=512); expected routes are hand-derived swaps.
module tb_benes_route_pipe;
    localparam int DATA_W  = 512;
    localparam int N_PORTS = 20;
    localparam int CFG_W   = 144;
`ifdef BENES_PIPE_HALF_EN
    localparam int L = 7;
`else
    localparam int L = 11;
`endif
    typedef logic [N_PORTS-1:0][DATA_W-1:0] vec_t;

    logic clk = 1'b0;
    logic rst_n, cfg_valid, cfg_ready, i_valid, o_valid, o_busy;
    logic [CFG_W-1:0] cfg_sel, cfg_swap3, cfg_s4s0, cfg_mix;
    vec_t din, dout, e;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    benes_route_pipe #(.DATA_W(DATA_W), .N_PORTS(N_PORTS)) dut (
        .clk(clk), .rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
        .i_cfg_sel(cfg_sel), .i_valid(i_valid), .i_data(din),
        .o_valid(o_valid), .o_data(dout), .o_busy(o_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t pat(input int base);
        vec_t r;
        for (int p = 0; p < N_PORTS; p++) begin
            r[p] = DATA_W'(base * 256 + p);
            r[p][DATA_W-1 -: 16] = 16'(base);
        end
        return r;
    endfunction

    function automatic vec_t swp(input vec_t v, input int a, input int b);
        vec_t r;
        r = v;
        r[a] = v[b];
        r[b] = v[a];
        return r;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input vec_t exp);
        int bp;
        bp = 0;
        for (int p = N_PORTS - 1; p >= 0; p--) if (dout[p] !== exp[p]) bp = p;
        total++;
        assert (dout === exp) else begin
            bad++;
            $error("FAIL %s: port %0d got %0h want %0h", tag, bp, dout[bp][63:0], exp[bp][63:0]);
        end
    endtask

    initial begin
        cfg_swap3 = '0; cfg_swap3[3] = 1'b1;             // stage0 sw3: 3<->19
        cfg_s4s0  = '0; cfg_s4s0[64] = 1'b1;             // stage4 sw0: 0<->1
        cfg_mix   = cfg_s4s0; cfg_mix[8*16+3] = 1'b1;    // plus stage8 sw3: 3<->19
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_sel = '0; i_valid = 1'b1; din = pat(7);

        // reset, with a beat offered throughout
        for (int c = 0; c < 3; c++) begin
            step();
            chk1("rst_vld", o_valid, 1'b0);
            chk1("rst_busy", o_busy, 1'b0);
            chk1("rst_rdy", cfg_ready, 1'b1);
            chk_data("rst_data", '0);
        end
        rst_n = 1'b1; i_valid = 1'b0;
        for (int c = 0; c < L + 2; c++) begin
            chk1("rst_no_vld", o_valid, 1'b0);
            step();
        end

        // identity beat, latency and busy window
        din = pat(0); i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            chk1("t2_busy", o_busy, k <= L);
            chk1("t2_vld", o_valid, k == L);
            if (k == L) chk_data("t2_data", pat(0));
            step();
        end

        // single switch in stage 0
        cfg_sel = cfg_swap3; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk1("t3_rdy_full", cfg_ready, 1'b0);
        din = pat(1); din[3] = DATA_W'('hA); din[19] = DATA_W'('hB); i_valid = 1'b1;
        #1;
        chk1("t3_rdy_beat", cfg_ready, 1'b1);
        e = swp(din, 3, 19);
        step();
        i_valid = 1'b0;
        repeat (L - 1) step();
        chk1("t3_vld", o_valid, 1'b1);
        chk_data("t3_data", e);
        step();
        chk1("t3_vld_off", o_valid, 1'b0);
        chk_data("t3_hold", e);

        // back-to-back beats, config changes every cycle
        cfg_sel = '0; cfg_valid = 1'b1;
        step();
        for (int c = 0; c < L + 9; c++) begin
            chk1("t4_vld", o_valid, (c >= L) && (c < L + 8));
            if ((c >= L) && (c < L + 8))
                chk_data("t4_data", ((c - L) % 2 == 1) ? swp(pat(16 + c - L), 3, 19) : pat(16 + c - L));
            if (c < 8) begin
                i_valid = 1'b1; cfg_valid = 1'b1; din = pat(16 + c);
                cfg_sel = ((c + 1) % 2 == 1) ? cfg_swap3 : '0;
            end else begin
                i_valid = 1'b0; cfg_valid = 1'b0;
            end
            step();
        end

        // reset with beats in flight
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            din = pat(60 + c);
            step();
        end
        i_valid = 1'b0;
        chk1("t6_busy_pre", o_busy, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < L + 4; c++) begin
            chk1("t6_no_vld", o_valid, 1'b0);
            chk1("t6_busy", o_busy, 1'b0);
            step();
        end

        // pending slot blocks a second config until the next beat
        cfg_sel = cfg_swap3; cfg_valid = 1'b1;
        step();
        cfg_sel = cfg_s4s0;
        for (int c = 0; c < 4; c++) begin
            chk1("t5_rdy_idle", cfg_ready, 1'b0);
            step();
        end
        din = pat(40); i_valid = 1'b1;
        #1;
        chk1("t5_rdy_beat", cfg_ready, 1'b1);
        step();
        din = pat(41); cfg_valid = 1'b0;
        step();
        i_valid = 1'b0;
        repeat (L - 2) step();
        chk1("t5_vld1", o_valid, 1'b1);
        chk_data("t5_cfg1", swp(pat(40), 3, 19));
        step();
        chk1("t5_vld2", o_valid, 1'b1);
        chk_data("t5_cfg2", swp(pat(41), 0, 1));
        step();
        chk1("t5_vld_off", o_valid, 1'b0);

        // middle and last stage together
        cfg_sel = cfg_mix; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0; din = pat(50); i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        repeat (L - 1) step();
        chk1("t7_vld", o_valid, 1'b1);
        chk_data("t7_data", swp(swp(pat(50), 3, 19), 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
